// File: rtl/fpu_regfile_sb.sv
// FPU register file (32 FPRs + FIR/FCSR control registers) with a load scoreboard
// that stalls COP1 decode on hazards against outstanding LWC1 destinations.
module fpu_regfile_sb #(
    parameter int unsigned MAX_LOADS  = 2,
    parameter logic [31:0] FIR_VALUE  = 32'h0000_0000,
    parameter logic [31:0] FCSR_WMASK = 32'h0183_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic        issue_re1,
    input  logic [4:0]  issue_raddr1,
    input  logic        issue_re2,
    input  logic [4:0]  issue_raddr2,
    input  logic        issue_r2_fcr,
    input  logic        issue_we,
    input  logic [4:0]  issue_waddr,
    input  logic        issue_w_fcr,
    input  logic        issue_is_load,
    output logic        stall,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic        wb_fcr,
    input  logic [31:0] wb_wdata,
    input  logic        ld_valid,
    input  logic [4:0]  ld_waddr,
    input  logic [31:0] ld_wdata,
    output logic [31:0] pending,
    output logic [2:0]  ld_count,
    output logic        ld_err
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 3;

    logic [XLEN-1:0] fpr_q [NREG];
    logic [XLEN-1:0] fpr_d [NREG];
    logic [XLEN-1:0] fcsr_q, fcsr_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   ld_count_q, ld_count_d;
    logic            ld_err_q, ld_err_d;

    logic [NREG-1:0] ld_clr, eff;
    logic            wb_fpr, wb_fcsr;
    logic [XLEN-1:0] fcsr_wr_val;
    logic [CW:0]     cnt_eff;
    logic            hazard, accept_load;

    // A load returning this cycle resolves its own hazard.
    always_comb begin
        ld_clr      = ld_valid ? (NREG'(1) << ld_waddr) : '0;
        eff         = pending_q & ~ld_clr;
        wb_fpr      = wb_we & ~wb_fcr;
        wb_fcsr     = wb_we & wb_fcr & (wb_waddr == 5'd31);
        fcsr_wr_val = (fcsr_q & ~FCSR_WMASK) | (wb_wdata & FCSR_WMASK);
        cnt_eff     = {1'b0, ld_count_q} - (CW+1)'(ld_valid);
    end

    always_comb begin
        hazard = (issue_re1 & eff[issue_raddr1])
               | (issue_re2 & ~issue_r2_fcr & eff[issue_raddr2])
               | (issue_we & ~issue_w_fcr & eff[issue_waddr])
               | (issue_is_load & (cnt_eff == (CW+1)'(MAX_LOADS)));
        stall       = issue_valid & hazard;
        accept_load = issue_valid & ~hazard & issue_is_load;
    end

    // Read ports with writeback bypass, then load bypass, then array.
    always_comb begin
        if (wb_fpr && wb_waddr == issue_raddr1)
            rdata1 = wb_wdata;
        else if (ld_valid && ld_waddr == issue_raddr1)
            rdata1 = ld_wdata;
        else
            rdata1 = fpr_q[issue_raddr1];

        if (issue_r2_fcr) begin
            case (issue_raddr2)
                5'd0:    rdata2 = FIR_VALUE;
                5'd31:   rdata2 = wb_fcsr ? fcsr_wr_val : fcsr_q;
                default: rdata2 = '0;
            endcase
        end else if (wb_fpr && wb_waddr == issue_raddr2) begin
            rdata2 = wb_wdata;
        end else if (ld_valid && ld_waddr == issue_raddr2) begin
            rdata2 = ld_wdata;
        end else begin
            rdata2 = fpr_q[issue_raddr2];
        end
    end

    always_comb begin
        fpr_d = fpr_q;
        if (wb_fpr)
            fpr_d[wb_waddr] = wb_wdata;
        if (ld_valid)
            fpr_d[ld_waddr] = ld_wdata;

        fcsr_d    = wb_fcsr ? fcsr_wr_val : fcsr_q;
        pending_d = eff | (accept_load ? (NREG'(1) << issue_waddr) : '0);

        ld_count_d = ld_count_q;
        if (accept_load && !ld_valid)
            ld_count_d = ld_count_q + CW'(1);
        else if (ld_valid && !accept_load && ld_count_q != '0)
            ld_count_d = ld_count_q - CW'(1);

        ld_err_d = ld_err_q | (ld_valid & (~pending_q[ld_waddr] | (ld_count_q == '0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                fpr_q[i] <= '0;
            fcsr_q     <= '0;
            pending_q  <= '0;
            ld_count_q <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            fpr_q      <= fpr_d;
            fcsr_q     <= fcsr_d;
            pending_q  <= pending_d;
            ld_count_q <= ld_count_d;
            ld_err_q   <= ld_err_d;
        end
    end

    assign pending  = pending_q;
    assign ld_count = ld_count_q;
    assign ld_err   = ld_err_q;

endmodule
